generador_secuencia: RTL and testbench
======================================

// Module: generador_secuencia
// PURPOSE
//  Serial stimulus source for detector_secuencia: accepts a parallel word plus bit count, shifts it
//  out MSB-first on `dato`, holding each bit for BIT_CYCLES clocks. Also counts overlapping
//  occurrences of PATRON in the emitted stream, so the verifier has a golden count to compare with
//  pulses on `detectada`. Sits upstream of the detector in the FSM-optimisation layout bench.
// PARAMETERS
//  WIDTH       16       max frame length in bits
//  BIT_CYCLES  2        clocks each bit is held on dato (>=1)
//  PATRON      4'b1101  4-bit pattern counted, overlapping allowed
//  LW (local)  $clog2(WIDTH+1)  width of longitud
//  CW (local)  $clog2(WIDTH)    width of patrones (max WIDTH-3 hits)
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-high
//  carga      in   1      load request; accepted only when listo=1
//  palabra    in   WIDTH  frame data, right-justified: bit longitud-1 is sent first
//  longitud   in   LW     bits to send, 1..WIDTH
//  listo      out  1      ready to accept carga
//  dato       out  1      serial bit (drives detector dato)
//  valido     out  1      high while dato carries a frame bit
//  fin        out  1      one-cycle pulse after last bit's hold period
//  patrones   out  CW     PATRON hits in current/last frame
// BEHAVIOUR
//  Reset (async, any state): state=REPOSO, listo=1, dato=0, valido=0, fin=0, patrones=0,
//   shift reg, bit counter, hold counter, 4-bit history all 0. Mid-frame reset aborts with no fin.
//  REPOSO: listo=1. carga=1 with longitud in 1..WIDTH: capture palabra/longitud, clear patrones
//   and history, go ENVIO. longitud=0 or >WIDTH: ignored, stay REPOSO, patrones kept.
//  Latency: first bit on dato/valido=1 at the first edge after the accepting edge.
//  ENVIO: listo=0, valido=1. Each bit stays on dato exactly BIT_CYCLES clocks, then the next
//   lower bit follows with no gap. After longitud bits (longitud*BIT_CYCLES clocks) go FIN.
//  FIN: one cycle, fin=1, valido=0, dato=0, listo=0; then REPOSO.
//  carga while listo=0 is ignored. No queueing, no effect on the frame in flight.
//  History/count: when a new bit is first driven, hist <= {hist[2:0],bit}. If the new hist==PATRON
//   and at least 4 bits have been sent this frame, patrones increments on that same edge.
//   History does not carry across frames. Counter saturates at all-ones.
//  patrones holds its final value through FIN and REPOSO until the next accepted carga.
//  All outputs registered. No combinational path from inputs to outputs.
// STRUCTURE
//  Shared include generador_defs.vh: state encodings REPOSO/ENVIO/FIN, default PATRON, LW/CW macros.
//  One sub-module: contador_patron (4-bit history shift, compare to PATRON, saturating counter,
//   clear input).
//  Parent holds the FSM, shift register, bit counter and hold counter.
// TESTING (WIDTH=16, BIT_CYCLES=2, PATRON=1101)
//  1 Reset: assert reset mid-ENVIO at an arbitrary non-edge time -> listo=1, valido=0, dato=0,
//    fin=0, patrones=0 immediately, before the next clk edge. No fin pulse afterwards.
//  2 palabra=16'h1B5D, longitud=13: dato = 1101101011101 (each bit 2 clks), valido high 26 clks,
//    fin at clk 27 after accept, patrones=3. Drive detector_secuencia with dato and check
//    3 detectada pulses.
//  3 palabra=16'h000D, longitud=4, then 16'h0001, longitud=1: patrones=1 then 0.
//    History must not cross frames.
//  4 carga pulsed during ENVIO with different palabra -> ignored, original stream unchanged;
//    carga in the same cycle as fin -> ignored (listo=0); carga the next cycle -> accepted.
//  5 longitud=0 and longitud=17 -> no ENVIO, listo stays 1, patrones unchanged.
//    longitud=16 palabra=16'hDDDD -> 32 clks of data, patrones=4.
//  6 palabra=16'hFFFF, longitud=16 -> dato constant 1 for 32 clks, patrones=0, fin once.

Source files
------------

// File: rtl/generador_secuencia_pkg.sv
`default_nettype none
// ============================================================================
// Module      : generador_secuencia_pkg
// Description : Shared state encoding and default pattern for the serial
//               stimulus generator.
// Revision    : 1.0 - initial release
// ============================================================================
package generador_secuencia_pkg;

    // Frame sequencer states, explicitly encoded on two bits
    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        ENVIO  = 2'd1,
        FIN    = 2'd2
    } estado_t;

    // Pattern counted by default in the emitted stream
    localparam logic [3:0] c_patron_defecto = 4'b1101;

endpackage : generador_secuencia_pkg
`default_nettype wire

// File: rtl/generador_secuencia_contador_patron.sv
`default_nettype none
// ============================================================================
// Module      : contador_patron
// Description : 4-bit serial history with overlapping pattern match and a
//               saturating hit counter; synchronous clear at frame start.
// Revision    : 1.0 - initial release
// ============================================================================
module contador_patron #(
    parameter logic [3:0] PATRON = 4'b1101,
    parameter int         CW     = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          limpiar,
    input  logic          desplazar,
    input  logic          habilitar,
    input  logic          bit_entrada,
    output logic [CW-1:0] patrones
);

    logic [3:0]    r_hist;
    logic [CW-1:0] r_cuenta;
    logic [3:0]    w_hist_nuevo;

    assign w_hist_nuevo = {r_hist[2:0], bit_entrada};
    assign patrones     = r_cuenta;

    // Shift in each new bit; count a hit once four bits of this frame exist
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist   <= '0;
            r_cuenta <= '0;
        end else if (limpiar) begin
            r_hist   <= '0;
            r_cuenta <= '0;
        end else if (desplazar) begin
            r_hist <= w_hist_nuevo;
            if (habilitar && (w_hist_nuevo == PATRON) && (r_cuenta != {CW{1'b1}})) begin
                r_cuenta <= r_cuenta + 1'b1;
            end
        end
    end

endmodule : contador_patron
`default_nettype wire

// File: rtl/generador_secuencia.sv
`default_nettype none
// ============================================================================
// Module      : generador_secuencia
// Description : Serial stimulus source. Loads a right-justified word and
//               shifts it out MSB-first, each bit held BIT_CYCLES clocks,
//               while counting overlapping PATRON occurrences.
// Revision    : 1.0 - initial release
// ============================================================================
module generador_secuencia
    import generador_secuencia_pkg::*;
#(
    parameter int         WIDTH      = 16,
    parameter int         BIT_CYCLES = 2,
    parameter logic [3:0] PATRON     = c_patron_defecto,
    localparam int        LW         = $clog2(WIDTH + 1),
    localparam int        CW         = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             carga,
    input  logic [WIDTH-1:0] palabra,
    input  logic [LW-1:0]    longitud,
    output logic             listo,
    output logic             dato,
    output logic             valido,
    output logic             fin,
    output logic [CW-1:0]    patrones
);

    localparam int          c_hw       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [c_hw-1:0] c_hold_max = c_hw'(BIT_CYCLES - 1);
    localparam logic [LW-1:0]   c_width    = LW'(WIDTH);

    estado_t          r_estado;
    logic [WIDTH-1:0] r_shift;
    logic [LW-1:0]    r_longitud;
    logic [LW-1:0]    r_enviados;
    logic [c_hw-1:0]  r_hold;
    logic             r_listo;
    logic             r_dato;
    logic             r_valido;
    logic             r_fin;

    logic             w_longitud_ok;
    logic             w_acepta;
    logic             w_nuevo_bit;
    logic [LW-1:0]    w_desp;

    // Only lengths 1..WIDTH start a frame; the word is left-aligned so the
    // first bit to send always sits in the MSB of the shift register.
    assign w_longitud_ok = (longitud != '0) && (longitud <= c_width);
    assign w_acepta      = (r_estado == REPOSO) && carga && w_longitud_ok;
    assign w_desp        = c_width - longitud;
    assign w_nuevo_bit   = (r_estado == ENVIO) && (r_hold == '0) && (r_enviados != r_longitud);

    assign listo  = r_listo;
    assign dato   = r_dato;
    assign valido = r_valido;
    assign fin    = r_fin;

    // Frame sequencer: load, shift out with per-bit hold, one-cycle fin pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado   <= REPOSO;
            r_shift    <= '0;
            r_longitud <= '0;
            r_enviados <= '0;
            r_hold     <= '0;
            r_listo    <= 1'b1;
            r_dato     <= 1'b0;
            r_valido   <= 1'b0;
            r_fin      <= 1'b0;
        end else begin
            case (r_estado)
                REPOSO: begin
                    r_listo  <= 1'b1;
                    r_dato   <= 1'b0;
                    r_valido <= 1'b0;
                    r_fin    <= 1'b0;
                    if (w_acepta) begin
                        r_shift    <= palabra << w_desp;
                        r_longitud <= longitud;
                        r_enviados <= '0;
                        r_hold     <= '0;
                        r_listo    <= 1'b0;
                        r_estado   <= ENVIO;
                    end
                end
                ENVIO: begin
                    if (r_hold != '0) begin
                        r_hold <= r_hold - 1'b1;
                    end else if (r_enviados == r_longitud) begin
                        r_estado <= FIN;
                        r_fin    <= 1'b1;
                        r_valido <= 1'b0;
                        r_dato   <= 1'b0;
                    end else begin
                        r_dato     <= r_shift[WIDTH-1];
                        r_shift    <= r_shift << 1;
                        r_enviados <= r_enviados + 1'b1;
                        r_hold     <= c_hold_max;
                        r_valido   <= 1'b1;
                    end
                end
                FIN: begin
                    r_fin    <= 1'b0;
                    r_listo  <= 1'b1;
                    r_estado <= REPOSO;
                end
                default: begin
                    r_estado <= REPOSO;
                end
            endcase
        end
    end

    contador_patron #(
        .PATRON (PATRON),
        .CW     (CW)
    ) u_contador (
        .clk         (clk),
        .reset       (reset),
        .limpiar     (w_acepta),
        .desplazar   (w_nuevo_bit),
        .habilitar   (r_enviados >= LW'(3)),
        .bit_entrada (r_shift[WIDTH-1]),
        .patrones    (patrones)
    );

endmodule : generador_secuencia
`default_nettype wire

// File: tb/tb_generador_secuencia.sv
`default_nettype none
// ============================================================================
// Module      : tb_generador_secuencia
// Description : Self-checking bench for generador_secuencia (WIDTH=16,
//               BIT_CYCLES=2, PATRON=1101). Expected serial bits are queued
//               at load time and popped while valido is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_generador_secuencia;

    logic        clk = 1'b0;
    logic        reset;
    logic        carga;
    logic [15:0] palabra;
    logic [4:0]  longitud;
    logic        listo;
    logic        dato;
    logic        valido;
    logic        fin;
    logic [3:0]  patrones;

    int vectors     = 0;
    int miscompares = 0;
    int n_valido    = 0;
    int n_fin       = 0;
    bit q_esperado[$];

    generador_secuencia #(
        .WIDTH      (16),
        .BIT_CYCLES (2),
        .PATRON     (4'b1101)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .carga    (carga),
        .palabra  (palabra),
        .longitud (longitud),
        .listo    (listo),
        .dato     (dato),
        .valido   (valido),
        .fin      (fin),
        .patrones (patrones)
    );

    always #5 clk = ~clk;

    // Scoreboard: every valido cycle must match the next queued bit
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (fin === 1'b1) n_fin++;
            if (valido === 1'b1) begin
                n_valido++;
                vectors++;
                if (q_esperado.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream: unexpected bit dato=%b with empty queue at %0t", dato, $time);
                end else begin
                    bit exp_b;
                    exp_b = q_esperado.pop_front();
                    if (dato !== exp_b) begin
                        miscompares++;
                        $display("FAIL stream: dato=%b expected=%b at %0t", dato, exp_b, $time);
                    end
                end
            end
        end
    end

    // Independent reference: overlapping 1101 windows across the sent bits
    function automatic int modelo_patrones(input logic [15:0] p, input int l);
        int c = 0;
        for (int j = 0; j + 3 < l; j++) begin
            logic [3:0] w;
            w = {p[l-1-j], p[l-2-j], p[l-3-j], p[l-4-j]};
            if (w == 4'b1101) c++;
        end
        return c;
    endfunction

    task automatic push_frame(input logic [15:0] p, input int l);
        for (int i = l - 1; i >= 0; i--) begin
            q_esperado.push_back(p[i]);
            q_esperado.push_back(p[i]);
        end
    endtask

    // Drive one load cycle; returns at the first negedge after the accept edge
    task automatic lanzar(input logic [15:0] p, input int l);
        n_valido = 0;
        n_fin    = 0;
        push_frame(p, l);
        carga    = 1'b1;
        palabra  = p;
        longitud = 5'(l);
        @(negedge clk);
        carga = 1'b0;
    endtask

    task automatic esperar_fin(input int inicio, output int ciclos, output bit ok);
        ciclos = inicio;
        while ((fin !== 1'b1) && (ciclos < 200)) begin
            @(negedge clk);
            ciclos++;
        end
        ok = (fin === 1'b1);
    endtask

    // Full frame scenario with latency, length, count and fin checks
    task automatic ejecutar_trama(input logic [15:0] p, input int l, input string nombre);
        int ciclos;
        bit ok;
        int exp_pat;
        exp_pat = modelo_patrones(p, l);
        lanzar(p, l);
        vectors++;
        if (listo !== 1'b0 || valido !== 1'b0) begin
            miscompares++;
            $display("FAIL %s accept: listo=%b valido=%b expected 0 0", nombre, listo, valido);
        end
        esperar_fin(1, ciclos, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s timeout: no fin within %0d cycles", nombre, ciclos);
        end else if (ciclos != 2 * l + 2) begin
            miscompares++;
            $display("FAIL %s fin latency: got %0d expected %0d", nombre, ciclos, 2 * l + 2);
        end
        vectors++;
        if (patrones !== 4'(exp_pat)) begin
            miscompares++;
            $display("FAIL %s patrones: got %0d expected %0d", nombre, patrones, exp_pat);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (n_valido != 2 * l || n_fin != 1 || q_esperado.size() != 0) begin
            miscompares++;
            $display("FAIL %s frame: valido_cycles=%0d fin_pulses=%0d left=%0d expected %0d 1 0",
                     nombre, n_valido, n_fin, q_esperado.size(), 2 * l);
        end
        vectors++;
        if (listo !== 1'b1 || patrones !== 4'(exp_pat)) begin
            miscompares++;
            $display("FAIL %s hold: listo=%b patrones=%0d expected 1 %0d", nombre, listo, patrones, exp_pat);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        carga    = 1'b0;
        palabra  = '0;
        longitud = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({listo, valido, dato, fin, patrones} !== 8'b1000_0000) begin
            miscompares++;
            $display("FAIL reset_state: listo=%b valido=%b dato=%b fin=%b patrones=%0d expected 1 0 0 0 0",
                     listo, valido, dato, fin, patrones);
        end
        reset = 1'b0;
        @(negedge clk);
        lanzar(16'h1B5D, 13);
        repeat (11) @(negedge clk);
        vectors++;
        if (valido !== 1'b1 || patrones !== 4'd1) begin
            miscompares++;
            $display("FAIL reset_midframe_pre: valido=%b patrones=%0d expected 1 1", valido, patrones);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({listo, valido, dato, fin, patrones} !== 8'b1000_0000) begin
            miscompares++;
            $display("FAIL reset_async: listo=%b valido=%b dato=%b fin=%b patrones=%0d expected 1 0 0 0 0",
                     listo, valido, dato, fin, patrones);
        end
        q_esperado.delete();
        @(negedge clk);
        reset = 1'b0;
        n_fin = 0;
        repeat (40) @(negedge clk);
        vectors++;
        if (n_fin != 0 || listo !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_abort: fin_pulses=%0d listo=%b expected 0 1", n_fin, listo);
        end
    endtask

    task automatic test_basico();
        ejecutar_trama(16'h1B5D, 13, "basico");
    endtask

    task automatic test_historia();
        ejecutar_trama(16'h000D, 4, "hist_a");
        ejecutar_trama(16'h0001, 1, "hist_b");
    endtask

    task automatic test_carga_ignorada();
        int ciclos;
        bit ok;
        lanzar(16'h1B5D, 13);
        repeat (5) @(negedge clk);
        carga    = 1'b1;
        palabra  = 16'hFFFF;
        longitud = 5'd16;
        @(negedge clk);
        carga = 1'b0;
        esperar_fin(7, ciclos, ok);
        vectors++;
        if (!ok || ciclos != 28 || patrones !== 4'd3) begin
            miscompares++;
            $display("FAIL busy_carga: ok=%b fin_cycle=%0d patrones=%0d expected 1 28 3", ok, ciclos, patrones);
        end
        carga    = 1'b1;
        palabra  = 16'h000D;
        longitud = 5'd4;
        @(negedge clk);
        vectors++;
        if (listo !== 1'b1 || valido !== 1'b0 || q_esperado.size() != 0) begin
            miscompares++;
            $display("FAIL fin_carga: listo=%b valido=%b left=%0d expected 1 0 0", listo, valido, q_esperado.size());
        end
        push_frame(16'h000D, 4);
        n_valido = 0;
        n_fin    = 0;
        @(negedge clk);
        carga = 1'b0;
        vectors++;
        if (listo !== 1'b0) begin
            miscompares++;
            $display("FAIL next_carga: listo=%b expected 0", listo);
        end
        esperar_fin(1, ciclos, ok);
        vectors++;
        if (!ok || ciclos != 10 || patrones !== 4'd1) begin
            miscompares++;
            $display("FAIL next_frame: ok=%b fin_cycle=%0d patrones=%0d expected 1 10 1", ok, ciclos, patrones);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (n_valido != 8 || n_fin != 1 || q_esperado.size() != 0) begin
            miscompares++;
            $display("FAIL next_stream: valido_cycles=%0d fin_pulses=%0d left=%0d expected 8 1 0",
                     n_valido, n_fin, q_esperado.size());
        end
    endtask

    task automatic test_longitud_invalida();
        int largos[2] = '{0, 17};
        foreach (largos[k]) begin
            carga    = 1'b1;
            palabra  = 16'hFFFF;
            longitud = 5'(largos[k]);
            @(negedge clk);
            carga = 1'b0;
            vectors++;
            if (listo !== 1'b1 || valido !== 1'b0) begin
                miscompares++;
                $display("FAIL bad_len_%0d: listo=%b valido=%b expected 1 0", largos[k], listo, valido);
            end
            repeat (3) @(negedge clk);
            vectors++;
            if (valido !== 1'b0 || patrones !== 4'd1) begin
                miscompares++;
                $display("FAIL bad_len_%0d_hold: valido=%b patrones=%0d expected 0 1", largos[k], valido, patrones);
            end
        end
        ejecutar_trama(16'hDDDD, 16, "full_dddd");
    endtask

    task automatic test_unos();
        ejecutar_trama(16'hFFFF, 16, "all_ones");
    endtask

    initial begin
        test_reset();
        test_basico();
        test_historia();
        test_carga_ignorada();
        test_longitud_invalida();
        test_unos();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_generador_secuencia
`default_nettype wire
